// File: rtl/cache_arbiter_pkg.sv
// cache_arbiter_pkg: shared types for the I/D cache miss arbiter.
//   lc3b_word    16-bit address/data word
//   lc3b_line    128-bit cache line
//   arb_state_t  grant FSM states
//   arb_client_t identity of the last granted client
package cache_arbiter_pkg;

   typedef logic [15:0]  lc3b_word;
   typedef logic [127:0] lc3b_line;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_I    = 2'd1,
      ARB_D    = 2'd2
   } arb_state_t;

   typedef enum logic {
      ARB_CLIENT_I = 1'b0,
      ARB_CLIENT_D = 1'b1
   } arb_client_t;

   // Lines are 16 bytes, so the low nibble of a byte address is dropped.
   localparam lc3b_word LINE_MASK = 16'hFFF0;

   function automatic lc3b_word line_align(input lc3b_word addr);
      return addr & LINE_MASK;
   endfunction

endpackage

// File: rtl/cache_arbiter_if.sv
// cache_arbiter_if: all client and memory-side signals of the arbiter.
//   I-cache : i_read, i_address -> ; <- i_rdata, i_resp
//   D-cache : d_read, d_write, d_address, d_wdata -> ; <- d_rdata, d_resp
//   memory  : <- pmem_read, pmem_write, pmem_address, pmem_wdata ;
//             pmem_rdata, pmem_resp ->
// modport slave  : the arbiter's view.
// modport master : the environment's view (caches plus physical memory).
interface cache_arbiter_if;
   import cache_arbiter_pkg::*;

   logic     i_read;
   lc3b_word i_address;
   lc3b_line i_rdata;
   logic     i_resp;

   logic     d_read;
   logic     d_write;
   lc3b_word d_address;
   lc3b_line d_wdata;
   lc3b_line d_rdata;
   logic     d_resp;

   logic     pmem_read;
   logic     pmem_write;
   lc3b_word pmem_address;
   lc3b_line pmem_wdata;
   lc3b_line pmem_rdata;
   logic     pmem_resp;

   modport slave (
      input  i_read, i_address, d_read, d_write, d_address, d_wdata,
             pmem_rdata, pmem_resp,
      output i_rdata, i_resp, d_rdata, d_resp,
             pmem_read, pmem_write, pmem_address, pmem_wdata
   );

   modport master (
      output i_read, i_address, d_read, d_write, d_address, d_wdata,
             pmem_rdata, pmem_resp,
      input  i_rdata, i_resp, d_rdata, d_resp,
             pmem_read, pmem_write, pmem_address, pmem_wdata
   );

endinterface

// File: rtl/cache_arbiter_mux2.sv
// mux2: generic two-input multiplexer.
//   sel   select (0 -> a, 1 -> b)
//   a, b  data inputs of parameterised width
//   f     selected output
module mux2 #(
   parameter int width = 16
) (
   input  logic             sel,
   input  logic [width-1:0] a,
   input  logic [width-1:0] b,
   output logic [width-1:0] f
);

   // Select between the two inputs.
   always_comb begin
      if (sel) begin
         f = b;
      end else begin
         f = a;
      end
   end

endmodule

// File: rtl/cache_arbiter.sv
// cache_arbiter: serialises I-cache and D-cache line misses onto one
// physical-memory port, one 128-bit line at a time, with a Moore grant FSM
// and round-robin tie-breaking.
//   clk    system clock, rising edge
//   reset  asynchronous, active-high; forces IDLE and last grant = I
//   bus    cache_arbiter_if.slave carrying the client and memory signals
module cache_arbiter
   import cache_arbiter_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   cache_arbiter_if.slave  bus
);

   arb_state_t  state_q, state_d;
   arb_client_t last_grant_q, last_grant_d;
   logic        d_req;
   lc3b_word    sel_addr;

   assign d_req = bus.d_read | bus.d_write;

   // Next-state and round-robin grant decision.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      case (state_q)
         ARB_IDLE: begin
            if (bus.i_read && d_req) begin
               // Tie: the side that did not win last time goes now.
               if (last_grant_q == ARB_CLIENT_I) begin
                  state_d      = ARB_D;
                  last_grant_d = ARB_CLIENT_D;
               end else begin
                  state_d      = ARB_I;
                  last_grant_d = ARB_CLIENT_I;
               end
            end else if (bus.i_read) begin
               state_d      = ARB_I;
               last_grant_d = ARB_CLIENT_I;
            end else if (d_req) begin
               state_d      = ARB_D;
               last_grant_d = ARB_CLIENT_D;
            end else begin
               state_d      = ARB_IDLE;
            end
         end
         ARB_I, ARB_D: begin
            // Completion always passes through IDLE, giving the mandatory gap.
            if (bus.pmem_resp) begin
               state_d = ARB_IDLE;
            end else begin
               state_d = state_q;
            end
         end
         default: begin
            state_d      = ARB_IDLE;
            last_grant_d = last_grant_q;
         end
      endcase
   end

   // State and last-grant registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ARB_IDLE;
         last_grant_q <= ARB_CLIENT_I;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
      end
   end

   mux2 #(.width(16)) u_addr_mux (
      .sel (state_q == ARB_D),
      .a   (bus.i_address),
      .b   (bus.d_address),
      .f   (sel_addr)
   );

   // Memory strobes/address decoded from state; resp pulses gated by pmem_resp.
   always_comb begin
      bus.pmem_read    = 1'b0;
      bus.pmem_write   = 1'b0;
      bus.pmem_address = 16'h0000;
      bus.pmem_wdata   = 128'h0;
      bus.i_resp       = 1'b0;
      bus.d_resp       = 1'b0;
      case (state_q)
         ARB_I: begin
            bus.pmem_read    = 1'b1;
            bus.pmem_address = line_align(sel_addr);
            bus.i_resp       = bus.pmem_resp;
         end
         ARB_D: begin
            // A simultaneous read and write request is handled as a write.
            bus.pmem_write   = bus.d_write;
            bus.pmem_read    = ~bus.d_write & bus.d_read;
            bus.pmem_address = line_align(sel_addr);
            bus.pmem_wdata   = bus.d_wdata;
            bus.d_resp       = bus.pmem_resp;
         end
         default: begin
            bus.pmem_read    = 1'b0;
         end
      endcase
   end

   // Read data is broadcast; only the resp pulses qualify it.
   assign bus.i_rdata = bus.pmem_rdata;
   assign bus.d_rdata = bus.pmem_rdata;

endmodule
